honeybee_sequencer: RTL and testbench

Sequences the honeybee collision accelerator on behalf of the core's main controller. Accepts one collision request at a time. Drives the accelerator's ap_start/ap_ready/ap_done block-level handshake and captures the 64-bit ap_return. Holds the result for the core's two writeback stages (EX_MUX takes the low word, MEM_MUX the high word). Also provides a watchdog timeout, a drain path, and performance counters.

---
 rtl/honeybee_sequencer_if.sv | 11 +
 rtl/honeybee_sequencer.sv | 79 +++++++
 tb/tb_honeybee_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/honeybee_sequencer_if.sv
// honeybee_sequencer_if: core-side request/response handshake of the collision sequencer
interface honeybee_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_collision;
    logic        rsp_timeout;
    modport master (output req_valid, rsp_ready, input req_ready, rsp_valid, rsp_collision, rsp_timeout);
    modport slave  (input req_valid, rsp_ready, output req_ready, rsp_valid, rsp_collision, rsp_timeout);
endinterface

// File: rtl/honeybee_sequencer.sv
// honeybee_sequencer: drives the honeybee accelerator handshake and holds its result for writeback
module honeybee_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    honeybee_sequencer_if.slave  core,
    output logic                 busy,
    output logic                 hb_ap_rst,
    output logic                 hb_ap_start,
    input  logic                 hb_ap_ready,
    input  logic                 hb_ap_done,
    input  logic                 hb_ap_idle,
    input  logic [63:0]          hb_ap_return,
    output logic [CNT_W-1:0]     op_count,
    output logic [CNT_W-1:0]     last_latency
);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, WAIT = 3'd2, RESP = 3'd3, DRAIN = 3'd4;
    localparam int WD_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [2:0]       state, nxt;
    logic [CNT_W-1:0] cnt;
    logic [WD_W-1:0]  wd;
    logic             pend, ok, expire;
    assign hb_ap_rst = rst;
    assign busy = state != IDLE;
    assign core.req_ready = state == IDLE;
    assign ok = hb_ap_done && ((state == START && hb_ap_ready) || state == WAIT);
    assign expire = (TIMEOUT_CYCLES != 0) && state == WAIT && !hb_ap_done && 32'(wd) == TIMEOUT_CYCLES - 1;
    // next state; a done pulse in RESP retires the pending abandoned op so no drain is needed
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = core.req_valid ? START : IDLE;
            START:   nxt = hb_ap_ready ? (hb_ap_done ? RESP : WAIT) : START;
            WAIT:    nxt = (hb_ap_done || expire) ? RESP : WAIT;
            RESP:    nxt = core.rsp_ready ? ((pend && !hb_ap_done) ? DRAIN : IDLE) : RESP;
            DRAIN:   nxt = (hb_ap_done || hb_ap_idle) ? IDLE : DRAIN;
            default: nxt = IDLE;
        endcase
    end
    // registered handshake outputs, result capture, watchdog and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hb_ap_start <= 1'b0;
            core.rsp_valid <= 1'b0;
            core.rsp_timeout <= 1'b0;
            core.rsp_collision <= '0;
            op_count <= '0;
            last_latency <= '0;
            cnt <= '0;
            wd <= '0;
            pend <= 1'b0;
        end else begin
            state <= nxt;
            hb_ap_start <= nxt == START;
            core.rsp_valid <= nxt == RESP;
            if (state == IDLE && core.req_valid)
                cnt <= CNT_W'(1);
            else if (state == START || state == WAIT)
                cnt <= &cnt ? cnt : cnt + CNT_W'(1);
            wd <= state == START ? '0 : state == WAIT ? wd + WD_W'(1) : wd;
            if (ok) begin
                core.rsp_collision <= hb_ap_return;
                core.rsp_timeout <= 1'b0;
                op_count <= op_count + CNT_W'(1);
                last_latency <= cnt;
            end
            if (expire) begin
                core.rsp_collision <= '0;
                core.rsp_timeout <= 1'b1;
                pend <= 1'b1;
            end
            if ((state == RESP && hb_ap_done) || (state == DRAIN && (hb_ap_done || hb_ap_idle)))
                pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_honeybee_sequencer.sv
// tb_honeybee_sequencer: vector table plus corner sequences against a response scoreboard
module tb_honeybee_sequencer;
    localparam int TO = 8;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;
    logic clk = 0;
    logic rst = 1;
    logic busy, hb_ap_rst, hb_ap_start;
    logic hb_ap_ready = 0, hb_ap_done = 0, hb_ap_idle = 0;
    logic [63:0] hb_ap_return = 0;
    logic [CW-1:0] op_count, last_latency;
    honeybee_sequencer_if bus();
    honeybee_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .core(bus), .busy(busy), .hb_ap_rst(hb_ap_rst),
        .hb_ap_start(hb_ap_start), .hb_ap_ready(hb_ap_ready), .hb_ap_done(hb_ap_done),
        .hb_ap_idle(hb_ap_idle), .hb_ap_return(hb_ap_return),
        .op_count(op_count), .last_latency(last_latency)
    );
    always #5 clk = ~clk;
    typedef struct { logic [63:0] col; logic to; } rsp_t;
    typedef struct { int rd; int dd; logic [63:0] ret; logic to; int hold; } vec_t;
    rsp_t q[$];
    vec_t vt[7];
    int total = 0, bad = 0, exp_ops = 0, exp_lat = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // rd: START cycle in which ready arrives; dd: cycles from ready to done; hold: backpressure cycles
    task automatic op(input int rd, input int dd, input logic [63:0] ret, input logic to, input int hold);
        int k, starts, want;
        rsp_t e;
        starts = 0;
        want = to ? rd + TO : rd + dd;
        q.push_back('{to ? 64'd0 : ret, to});
        chk("req_ready", 64'(bus.req_ready), 1);
        bus.req_valid = 1;
        tick;
        bus.req_valid = 0;
        for (k = 1; k <= 60; k++) begin
            starts += int'(hb_ap_start);
            hb_ap_ready = k == rd;
            hb_ap_done = !to && k == rd + dd;
            hb_ap_return = hb_ap_done ? ret : 64'h0BAD_0BAD_0BAD_0BAD;
            tick;
            hb_ap_ready = 0;
            hb_ap_done = 0;
            if (bus.rsp_valid) break;
        end
        if (!to) begin
            exp_ops++;
            exp_lat = want > SAT ? SAT : want;
        end
        e = q.pop_front();
        chk("rsp_valid", 64'(bus.rsp_valid), 1);
        chk("rsp_cycles", 64'(k), 64'(want));
        chk("ap_start_cycles", 64'(starts), 64'(rd));
        chk("rsp_collision", bus.rsp_collision, e.col);
        chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.to));
        chk("op_count", 64'(op_count), 64'(exp_ops % (SAT + 1)));
        chk("last_latency", 64'(last_latency), 64'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = 1;
            hb_ap_done = h == 3;
            hb_ap_return = 64'hFFFF_FFFF_FFFF_FFFF;
            tick;
            hb_ap_done = 0;
            chk("hold_valid", 64'(bus.rsp_valid), 1);
            chk("hold_collision", bus.rsp_collision, e.col);
            chk("hold_req_ready", 64'(bus.req_ready), 0);
            chk("hold_no_start", 64'(hb_ap_start), 0);
        end
        bus.req_valid = 0;
        bus.rsp_ready = 1;
        tick;
        bus.rsp_ready = 0;
        chk("rsp_drop", 64'(bus.rsp_valid), 0);
    endtask

    initial begin
        bus.req_valid = 0;
        bus.rsp_ready = 0;
        vt[0] = '{2, 5, 64'h0000_0001_0000_0000, 0, 0};
        vt[1] = '{1, 0, 64'hDEAD_BEEF_CAFE_F00D, 0, 0};
        vt[2] = '{3, 8, 64'h1234_5678_9ABC_DEF0, 0, 0};
        vt[3] = '{20, 2, 64'h0F0F_0F0F_F0F0_F0F0, 0, 0};
        vt[4] = '{2, 1, 64'h8000_0000_0000_0001, 0, 20};
        vt[5] = '{1, 1, 64'h0000_0000_FFFF_FFFF, 0, 0};
        vt[6] = '{1, 3, 64'h5555_AAAA_5555_AAAA, 0, 0};
        tick;
        chk("ap_rst_in_reset", 64'(hb_ap_rst), 1);
        tick;
        rst = 0;
        chk("reset_busy", 64'(busy), 0);
        chk("reset_req_ready", 64'(bus.req_ready), 1);
        chk("reset_valid", 64'(bus.rsp_valid), 0);
        chk("reset_start", 64'(hb_ap_start), 0);
        chk("reset_collision", bus.rsp_collision, 0);
        chk("reset_op_count", 64'(op_count), 0);
        chk("reset_latency", 64'(last_latency), 0);
        chk("ap_rst_released", 64'(hb_ap_rst), 0);
        for (int i = 0; i < 7; i++) begin
            op(vt[i].rd, vt[i].dd, vt[i].ret, vt[i].to, vt[i].hold);
            tick;
        end
        op(1, 0, 64'd0, 1, 0);
        chk("drain_busy", 64'(busy), 1);
        chk("drain_req_ready", 64'(bus.req_ready), 0);
        tick;
        tick;
        chk("drain_still_busy", 64'(busy), 1);
        hb_ap_done = 1;
        hb_ap_return = 64'h7777_7777_7777_7777;
        tick;
        hb_ap_done = 0;
        chk("drain_exit", 64'(busy), 0);
        chk("drain_collision", bus.rsp_collision, 0);
        chk("drain_op_count", 64'(op_count), 64'(exp_ops % (SAT + 1)));
        op(2, 0, 64'd0, 1, 0);
        hb_ap_idle = 1;
        tick;
        hb_ap_idle = 0;
        chk("drain_idle_exit", 64'(busy), 0);
        op(1, 0, 64'd0, 1, 5);
        chk("resp_done_clears_pend", 64'(busy), 0);
        hb_ap_done = 1;
        hb_ap_return = 64'h3333_3333_3333_3333;
        tick;
        hb_ap_done = 0;
        chk("stray_done_valid", 64'(bus.rsp_valid), 0);
        chk("stray_done_busy", 64'(busy), 0);
        chk("stray_done_collision", bus.rsp_collision, 0);
        chk("stray_done_op_count", 64'(op_count), 64'(exp_ops % (SAT + 1)));
        bus.req_valid = 1;
        tick;
        bus.req_valid = 0;
        hb_ap_ready = 1;
        tick;
        hb_ap_ready = 0;
        tick;
        tick;
        chk("wait_busy", 64'(busy), 1);
        rst = 1;
        #1;
        chk("mid_reset_ap_rst", 64'(hb_ap_rst), 1);
        tick;
        rst = 0;
        exp_ops = 0;
        exp_lat = 0;
        chk("mid_reset_busy", 64'(busy), 0);
        chk("mid_reset_start", 64'(hb_ap_start), 0);
        chk("mid_reset_valid", 64'(bus.rsp_valid), 0);
        chk("mid_reset_op_count", 64'(op_count), 0);
        chk("mid_reset_latency", 64'(last_latency), 0);
        chk("mid_reset_collision", bus.rsp_collision, 0);
        for (int i = 0; i <= SAT; i++) op(1, 0, 64'(i + 100), 0, 0);
        chk("op_count_wrap", 64'(op_count), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
